iob_split_reg: RTL and testbench

IOB_SPLIT_REG -- requirements
Module: iob_split_reg

---
 rtl/iob_split_reg_pkg.sv | 18 +
 rtl/iob_split_reg_if.sv | 19 +
 rtl/iob_split_tmo.sv | 19 +
 rtl/iob_split_reg.sv | 100 ++++++++++
 tb/tb_iob_split_reg.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iob_split_reg_pkg.sv
// iob_split_reg_pkg: shared widths, field offsets and state encoding for the address-split bridge
package iob_split_reg_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   localparam int RESP_RDY_BIT = 0;
   localparam int RESP_RDATA_LSB = 1;
   function automatic int req_w(int addr_w, int data_w);
      return 1 + addr_w + data_w + data_w / 8;
   endfunction
   function automatic int resp_w(int data_w);
      return data_w + 1;
   endfunction
   function automatic int wdata_lsb(int data_w);
      return data_w / 8;
   endfunction
   function automatic int addr_lsb(int data_w);
      return data_w / 8 + data_w;
   endfunction
endpackage

// File: rtl/iob_split_reg_if.sv
// iob_split_reg_if: master-side request/response plus the fanned-out slave buses and error pulses
interface iob_split_reg_if
   import iob_split_reg_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int N_SLAVES = 4
);
   localparam int REQ_W  = req_w(ADDR_W, DATA_W);
   localparam int RESP_W = resp_w(DATA_W);
   logic [REQ_W-1:0]           m_req;
   logic [RESP_W-1:0]          m_resp;
   logic [N_SLAVES*REQ_W-1:0]  s_req;
   logic [N_SLAVES*RESP_W-1:0] s_resp;
   logic                       err_unmapped;
   logic                       err_timeout;
   modport master (output m_req, s_resp, input m_resp, s_req, err_unmapped, err_timeout);
   modport slave  (input m_req, s_resp, output m_resp, s_req, err_unmapped, err_timeout);
endinterface

// File: rtl/iob_split_tmo.sv
// iob_split_tmo: wait-cycle counter that flags the last cycle a slave is allowed before timing out
module iob_split_tmo #(
   parameter int TIMEOUT_W = 8,
   parameter int TIMEOUT   = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   logic [TIMEOUT_W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clear) cnt <= '0;
      else if (enable) cnt <= cnt + 1'b1;
   // TIMEOUT of zero turns the watchdog off entirely
   assign expired = (TIMEOUT != 0) && (cnt == TIMEOUT_W'(TIMEOUT - 1));
endmodule

// File: rtl/iob_split_reg.sv
// iob_split_reg: routes one native-bus master to N slaves by address field, with registered
// response, unmapped-select error and slave timeout
module iob_split_reg
   import iob_split_reg_pkg::*;
#(
   parameter int              ADDR_W    = 32,
   parameter int              DATA_W    = 32,
   parameter int              N_SLAVES  = 4,
   parameter int              P_SLAVES  = ADDR_W - 2,
   parameter int              TIMEOUT_W = 8,
   parameter int              TIMEOUT   = 255,
   parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
   input logic            clk,
   input logic            rst_n,
   iob_split_reg_if.slave bus
);
   localparam int REQ_W    = req_w(ADDR_W, DATA_W);
   localparam int RESP_W   = resp_w(DATA_W);
   localparam int SEL_W    = $clog2(N_SLAVES);
   localparam int ADDR_LSB = addr_lsb(DATA_W);

   state_t              state_q, state_d;
   logic [REQ_W-2:0]    req_q;
   logic [SEL_W-1:0]    sel_q, sel;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                unm_q, unm_d, tmo_q, tmo_d;
   logic                ld, rd_ld, expired, m_valid, unmapped, rdy;
   logic [N_SLAVES-1:0] s_rdy;
   logic [DATA_W-1:0]   s_rdata [N_SLAVES];

   assign m_valid  = bus.m_req[REQ_W-1];
   assign sel      = bus.m_req[ADDR_LSB + P_SLAVES -: SEL_W];
   assign unmapped = {1'b0, sel} >= (SEL_W + 1)'(N_SLAVES);
   assign rdy      = s_rdy[sel_q];

   for (genvar i = 0; i < N_SLAVES; i++) begin : g_slv
      assign bus.s_req[i*REQ_W +: REQ_W] = (state_q == BUSY && sel_q == SEL_W'(i)) ? {1'b1, req_q} : '0;
      assign s_rdy[i]   = bus.s_resp[i*RESP_W + RESP_RDY_BIT];
      assign s_rdata[i] = bus.s_resp[i*RESP_W + RESP_RDATA_LSB +: DATA_W];
   end

   iob_split_tmo #(.TIMEOUT_W(TIMEOUT_W), .TIMEOUT(TIMEOUT)) u_tmo (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (state_q != BUSY),
      .enable (state_q == BUSY && !rdy),
      .expired(expired)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else state_q <= state_d;

   always_comb begin
      state_d = state_q;
      ld      = 1'b0;
      rd_ld   = 1'b0;
      rdata_d = ERR_DATA;
      unm_d   = 1'b0;
      tmo_d   = 1'b0;
      case (state_q)
         IDLE: if (m_valid) begin
            state_d = unmapped ? RESP : BUSY;
            ld      = !unmapped;
            rd_ld   = unmapped;
            unm_d   = unmapped;
         end
         // a ready landing on the expiry cycle takes priority over the timeout
         BUSY: if (rdy || expired) begin
            state_d = RESP;
            rd_ld   = 1'b1;
            rdata_d = rdy ? s_rdata[sel_q] : ERR_DATA;
            tmo_d   = !rdy;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         req_q   <= '0;
         sel_q   <= '0;
         rdata_q <= '0;
         unm_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         if (ld) begin
            req_q <= bus.m_req[REQ_W-2:0];
            sel_q <= sel;
         end
         if (rd_ld) rdata_q <= rdata_d;
         unm_q <= unm_d;
         tmo_q <= tmo_d;
      end

   assign bus.m_resp       = {rdata_q, state_q == RESP};
   assign bus.err_unmapped = unm_q;
   assign bus.err_timeout  = tmo_q;
endmodule

// File: tb/tb_iob_split_reg.sv
// tb_iob_split_reg: scenario tasks with a response scoreboard for the address-split bridge
module tb_iob_split_reg;
   localparam int REQ_W  = 69;
   localparam int RESP_W = 33;
   localparam logic [31:0] ERR = 32'hDEADBEEF;

   typedef struct packed {logic [31:0] rdata; logic tmo;} exp_t;

   logic clk, rst_n;
   int   checks, failures;
   exp_t exp_q[$];
   exp_t sb_e;

   iob_split_reg_if #(.ADDR_W(32), .DATA_W(32), .N_SLAVES(4)) bus_a ();
   iob_split_reg_if #(.ADDR_W(32), .DATA_W(32), .N_SLAVES(3)) bus_b ();

   iob_split_reg #(.ADDR_W(32), .DATA_W(32), .N_SLAVES(4), .P_SLAVES(31), .TIMEOUT(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a));
   iob_split_reg #(.ADDR_W(32), .DATA_W(32), .N_SLAVES(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b));

   always #5 clk = ~clk;

   function automatic logic [REQ_W-1:0] sa(int i);
      return bus_a.s_req[i*REQ_W +: REQ_W];
   endfunction
   function automatic logic sv(int i);
      return bus_a.s_req[i*REQ_W + REQ_W - 1];
   endfunction
   function automatic logic others_zero(int keep);
      for (int j = 0; j < 4; j++) if (j != keep && sa(j) != '0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drive_m(logic v, logic [31:0] addr, logic [31:0] wd, logic [3:0] ws);
      bus_a.m_req = {v, addr, wd, ws};
   endtask
   task automatic drive_s(int i, logic rdy, logic [31:0] d);
      bus_a.s_resp[i*RESP_W +: RESP_W] = {d, rdy};
   endtask

   // every master response of dut_a is matched against the oldest expectation
   always @(negedge clk) begin
      if (rst_n && bus_a.m_resp[0]) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: rdata=%h tmo=%b with no response outstanding",
                     bus_a.m_resp[RESP_W-1:1], bus_a.err_timeout);
         end else begin
            sb_e = exp_q.pop_front();
            if (bus_a.m_resp[RESP_W-1:1] !== sb_e.rdata || bus_a.err_timeout !== sb_e.tmo) begin
               failures++;
               $display("FAIL sb_resp: rdata=%h tmo=%b, required rdata=%h tmo=%b",
                        bus_a.m_resp[RESP_W-1:1], bus_a.err_timeout, sb_e.rdata, sb_e.tmo);
            end
         end
      end
   end

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++;
      if (bus_a.m_resp !== '0 || bus_a.s_req !== '0 || bus_a.err_unmapped !== 1'b0 || bus_a.err_timeout !== 1'b0) begin
         failures++;
         $display("FAIL reset_a: m_resp=%h s_req=%h errs=%b%b, required all zero",
                  bus_a.m_resp, bus_a.s_req, bus_a.err_unmapped, bus_a.err_timeout);
      end
      checks++;
      if (bus_b.m_resp !== '0 || bus_b.s_req !== '0 || bus_b.err_unmapped !== 1'b0 || bus_b.err_timeout !== 1'b0) begin
         failures++;
         $display("FAIL reset_b: m_resp=%h s_req=%h, required all zero", bus_b.m_resp, bus_b.s_req);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write;
      logic [REQ_W-1:0] fwd, exp_s1;
      fwd = {1'b1, 32'h4000_0010, 32'hA5A5_0001, 4'b0110};
      drive_m(1'b1, 32'h4000_0010, 32'hA5A5_0001, 4'b0110);
      exp_q.push_back({32'h0BAD_F00D, 1'b0});
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         exp_s1 = (c <= 3) ? fwd : '0;
         checks++;
         if (sa(1) !== exp_s1 || bus_a.m_resp[0] !== (c == 4) || !others_zero(1)) begin
            failures++;
            $display("FAIL write_c%0d: s1=%h m_ready=%b others_zero=%b, required s1=%h m_ready=%b others_zero=1",
                     c, sa(1), bus_a.m_resp[0], others_zero(1), exp_s1, c == 4);
         end
         if (c == 3) drive_s(1, 1'b1, 32'h0BAD_F00D);
         if (c == 4) begin
            drive_s(1, 1'b0, 32'h0);
            drive_m(1'b0, 32'h0, 32'h0, 4'h0);
         end
      end
      checks++;
      if (bus_a.m_resp !== {32'h0BAD_F00D, 1'b0}) begin
         failures++;
         $display("FAIL write_hold: m_resp=%h, required %h", bus_a.m_resp, {32'h0BAD_F00D, 1'b0});
      end
   endtask

   task automatic test_read;
      drive_m(1'b1, 32'hC000_0004, 32'h0, 4'h0);
      exp_q.push_back({32'h1234_5678, 1'b0});
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         checks++;
         if (sv(3) !== (c <= 2) || bus_a.m_resp[0] !== (c == 3) || !others_zero(3)) begin
            failures++;
            $display("FAIL read_c%0d: s3_valid=%b m_ready=%b, required s3_valid=%b m_ready=%b",
                     c, sv(3), bus_a.m_resp[0], c <= 2, c == 3);
         end
         if (c == 2) drive_s(3, 1'b1, 32'h1234_5678);
         if (c == 3) begin
            checks++;
            if (bus_a.m_resp[RESP_W-1:1] !== 32'h1234_5678) begin
               failures++;
               $display("FAIL read_data: rdata=%h, required 12345678", bus_a.m_resp[RESP_W-1:1]);
            end
            drive_s(3, 1'b0, 32'h0);
            drive_m(1'b0, 32'h0, 32'h0, 4'h0);
         end
      end
   endtask

   task automatic test_timeout;
      drive_m(1'b1, 32'h8000_0000, 32'h77, 4'hF);
      exp_q.push_back({ERR, 1'b1});
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         checks++;
         if (sv(2) !== (c <= 4) || bus_a.m_resp[0] !== (c == 5) || bus_a.err_timeout !== (c == 5) || !others_zero(2)) begin
            failures++;
            $display("FAIL timeout_c%0d: s2_valid=%b m_ready=%b err_timeout=%b, required %b %b %b",
                     c, sv(2), bus_a.m_resp[0], bus_a.err_timeout, c <= 4, c == 5, c == 5);
         end
         if (c == 5) begin
            drive_m(1'b0, 32'h0, 32'h0, 4'h0);
            drive_s(2, 1'b1, 32'h0000_5555);
         end
         if (c == 7) drive_s(2, 1'b0, 32'h0);
      end
      checks++;
      if (bus_a.m_resp !== {ERR, 1'b0}) begin
         failures++;
         $display("FAIL timeout_late: m_resp=%h, required %h", bus_a.m_resp, {ERR, 1'b0});
      end
   endtask

   task automatic test_tmo_race;
      drive_m(1'b1, 32'h4000_0000, 32'h99, 4'h3);
      exp_q.push_back({32'hCAFE_0001, 1'b0});
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         checks++;
         if (sv(1) !== (c <= 4) || bus_a.m_resp[0] !== (c == 5) || bus_a.err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL race_c%0d: s1_valid=%b m_ready=%b err_timeout=%b, required %b %b 0",
                     c, sv(1), bus_a.m_resp[0], bus_a.err_timeout, c <= 4, c == 5);
         end
         if (c == 4) drive_s(1, 1'b1, 32'hCAFE_0001);
         if (c == 5) begin
            drive_s(1, 1'b0, 32'h0);
            drive_m(1'b0, 32'h0, 32'h0, 4'h0);
         end
      end
   endtask

   task automatic test_reset_mid_busy;
      drive_m(1'b1, 32'h8000_0000, 32'h1, 4'hF);
      repeat (2) @(negedge clk);
      checks++;
      if (sv(2) !== 1'b1) begin
         failures++;
         $display("FAIL rst_busy_pre: s2_valid=%b, required 1", sv(2));
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus_a.m_resp !== '0 || bus_a.s_req !== '0 || bus_a.err_timeout !== 1'b0 || bus_a.err_unmapped !== 1'b0) begin
         failures++;
         $display("FAIL rst_busy_async: m_resp=%h s_req=%h, required all zero", bus_a.m_resp, bus_a.s_req);
      end
      drive_m(1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive_m(1'b1, 32'h0000_0100, 32'h2, 4'h1);
      exp_q.push_back({32'h0000_1111, 1'b0});
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         checks++;
         if (sv(0) !== (c == 1) || bus_a.m_resp[0] !== (c == 2) || !others_zero(0)) begin
            failures++;
            $display("FAIL rst_busy_next_c%0d: s0_valid=%b m_ready=%b, required %b %b",
                     c, sv(0), bus_a.m_resp[0], c == 1, c == 2);
         end
         if (c == 1) drive_s(0, 1'b1, 32'h0000_1111);
         if (c == 2) begin
            drive_s(0, 1'b0, 32'h0);
            drive_m(1'b0, 32'h0, 32'h0, 4'h0);
         end
      end
   endtask

   task automatic test_back_to_back;
      int r1, v2, n;
      r1 = -1;
      v2 = -1;
      n  = 0;
      drive_m(1'b1, 32'h4000_0020, 32'h1, 4'hF);
      exp_q.push_back({32'h0000_B001, 1'b0});
      for (int c = 1; c <= 20 && n < 2; c++) begin
         @(negedge clk);
         if (bus_a.m_resp[0]) begin
            n++;
            if (n == 1) begin
               r1 = c;
               drive_m(1'b1, 32'h4000_0024, 32'h2, 4'hF);
               exp_q.push_back({32'h0000_B002, 1'b0});
            end else drive_m(1'b0, 32'h0, 32'h0, 4'h0);
         end
         if (n == 1 && sv(1) && v2 < 0) v2 = c;
         drive_s(1, sv(1), n == 0 ? 32'h0000_B001 : 32'h0000_B002);
      end
      drive_s(1, 1'b0, 32'h0);
      drive_m(1'b0, 32'h0, 32'h0, 4'h0);
      checks++;
      if (n != 2 || r1 < 0 || v2 < 0 || v2 - r1 < 2) begin
         failures++;
         $display("FAIL back_to_back: responses=%0d first_ready=%0d second_valid=%0d, required 2 responses and gap>=2",
                  n, r1, v2);
      end
      @(negedge clk);
   endtask

   task automatic test_unmapped;
      bus_b.m_req = {1'b1, 32'h6000_0000, 32'h0, 4'hF};
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         checks++;
         if (bus_b.m_resp !== {ERR, c == 1} || bus_b.err_unmapped !== (c == 1) ||
             bus_b.s_req !== '0 || bus_b.err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL unmapped_c%0d: m_resp=%h err_unmapped=%b s_req=%h, required m_resp=%h err_unmapped=%b s_req=0",
                     c, bus_b.m_resp, bus_b.err_unmapped, bus_b.s_req, {ERR, c == 1}, c == 1);
         end
         if (c == 1) bus_b.m_req = '0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      clk          = 1'b0;
      rst_n        = 1'b0;
      checks       = 0;
      failures     = 0;
      bus_a.m_req  = '0;
      bus_a.s_resp = '0;
      bus_b.m_req  = '0;
      bus_b.s_resp = '0;
      test_reset;
      test_write;
      test_read;
      test_timeout;
      test_tmo_race;
      test_reset_mid_busy;
      test_back_to_back;
      test_unmapped;
      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: %0d responses outstanding, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
